// File: rtl/fc_l2_arb_pkg.sv
// ----------------------------------------------------------------------------
// Module   : fc_l2_arb_pkg
// Shared types and constants for the FC L2 two-port arbiter.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fc_l2_arb_pkg;

    localparam int NB_PORTS = 2;

    typedef logic port_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lock_state_e;

endpackage

`default_nettype wire

// File: rtl/fc_l2_arb_id_fifo.sv
// ----------------------------------------------------------------------------
// Module   : fc_l2_arb_id_fifo
// In-order FIFO of issuing-port IDs for transactions awaiting r_valid.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fc_l2_arb_id_fifo
    import fc_l2_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  port_id_t push_id,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output port_id_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    port_id_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 1'b0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fc_l2_port_arbiter.sv
// ----------------------------------------------------------------------------
// Module   : fc_l2_port_arbiter
// Round-robin, grant-locking arbiter sharing one L2 TCDM master port between
// the FC data bus and a secondary master. Optional: FC_L2_ARB_PERF_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fc_l2_port_arbiter
    import fc_l2_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NB_PORTS-1:0]                      s_req_i,
    input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0]      s_add_i,
    input  logic [NB_PORTS-1:0]                      s_wen_i,
    input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]      s_wdata_i,
    input  logic [NB_PORTS-1:0][DATA_WIDTH/8-1:0]    s_be_i,
    output logic [NB_PORTS-1:0]                      s_gnt_o,
    output logic [NB_PORTS-1:0]                      s_r_valid_o,
    output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]      s_r_rdata_o,
    output logic                                     m_req_o,
    output logic [ADDR_WIDTH-1:0]                    m_add_o,
    output logic                                     m_wen_o,
    output logic [DATA_WIDTH-1:0]                    m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                  m_be_o,
    input  logic                                     m_gnt_i,
    input  logic                                     m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                    m_r_rdata_i,
    output logic                                     err_o,
    output logic [31:0]                              perf_gnt0_o,
    output logic [31:0]                              perf_gnt1_o,
    output logic [31:0]                              perf_stall_o
);

    lock_state_e state, state_next;
    port_id_t    locked_id, locked_id_next;
    port_id_t    rr_ptr;
    port_id_t    sel;
    port_id_t    head;
    logic        lock_hold;
    logic        full;
    logic        empty;
    logic        handshake;
    logic        drop_err;

    // A locked port that withdraws its request no longer steers the mux,
    // so the other port can never be issued with the dead port's payload.
    assign lock_hold = (state == WAIT) && s_req_i[locked_id];

    always_comb begin
        sel = rr_ptr;
        if (lock_hold) begin
            sel = locked_id;
        end else if (s_req_i == 2'b01) begin
            sel = 1'b0;
        end else if (s_req_i == 2'b10) begin
            sel = 1'b1;
        end
    end

    assign m_req_o   = (|s_req_i) & ~full & rst_ni;
    assign handshake = m_req_o & m_gnt_i;
    assign s_gnt_o   = handshake ? (2'b01 << sel) : 2'b00;

    assign m_add_o   = s_add_i[sel];
    assign m_wen_o   = s_wen_i[sel];
    assign m_wdata_o = s_wdata_i[sel];
    assign m_be_o    = s_be_i[sel];

    always_comb begin
        state_next     = state;
        locked_id_next = locked_id;
        drop_err       = 1'b0;
        case (state)
            IDLE: begin
                if (m_req_o && !m_gnt_i) begin
                    state_next     = WAIT;
                    locked_id_next = sel;
                end
            end
            WAIT: begin
                if (!s_req_i[locked_id]) begin
                    drop_err   = 1'b1;
                    state_next = IDLE;
                end else if (m_gnt_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            locked_id <= 1'b0;
            rr_ptr    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_next;
            locked_id <= locked_id_next;
            if (handshake) begin
                rr_ptr <= ~sel;
            end
            if (drop_err || (m_r_valid_i && empty)) begin
                err_o <= 1'b1;
            end
        end
    end

    fc_l2_arb_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .push    (handshake),
        .push_id (sel),
        .pop     (m_r_valid_i),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    assign s_r_valid_o    = (m_r_valid_i && !empty && rst_ni) ? (2'b01 << head) : 2'b00;
    assign s_r_rdata_o[0] = m_r_rdata_i;
    assign s_r_rdata_o[1] = m_r_rdata_i;

`ifdef FC_L2_ARB_PERF_EN
    logic [31:0] cnt_gnt0;
    logic [31:0] cnt_gnt1;
    logic [31:0] cnt_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_gnt0  <= '0;
            cnt_gnt1  <= '0;
            cnt_stall <= '0;
        end else begin
            if (handshake && !sel) begin
                cnt_gnt0 <= cnt_gnt0 + 32'd1;
            end
            if (handshake && sel) begin
                cnt_gnt1 <= cnt_gnt1 + 32'd1;
            end
            if ((|s_req_i) && !handshake) begin
                cnt_stall <= cnt_stall + 32'd1;
            end
        end
    end

    assign perf_gnt0_o  = cnt_gnt0;
    assign perf_gnt1_o  = cnt_gnt1;
    assign perf_stall_o = cnt_stall;
`else
    assign perf_gnt0_o  = '0;
    assign perf_gnt1_o  = '0;
    assign perf_stall_o = '0;
`endif

endmodule

`default_nettype wire
